// File: rtl/bus_clk_generator.sv
// Burst bus-clock generator: emits num_pulses cycles of a divided clock on
// clk_out, with registered edge strobes, a busy flag and a done strobe.
module bus_clk_generator #(
    parameter int unsigned CLK_DIV    = 3,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_pulses,
    input  logic                 stop,
    output logic                 clk_out,
    output logic                 rise_edge,
    output logic                 fall_edge,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state_q,  state_d;
    logic [DIV_W-1:0]     hcnt_q,   hcnt_d;
    logic [CNT_WIDTH-1:0] pulses_q, pulses_d;
    logic                 stop_q,   stop_d;
    logic                 clk_q,    clk_d;
    logic                 rise_q,   rise_d;
    logic                 fall_q,   fall_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic                 stop_req;

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        pulses_d = pulses_q;
        stop_d   = stop_q;
        clk_d    = clk_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        stop_req = stop | stop_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_pulses == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        hcnt_d   = '0;
                        pulses_d = num_pulses;
                        stop_d   = 1'b0;
                    end
                end
            end

            RUN: begin
                // An abort while parked at the idle level ends the burst at once
                // and suppresses any toggle that was due on this edge.
                if (stop_req && (clk_q == IDLE_LEVEL)) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    stop_d   = 1'b0;
                    hcnt_d   = '0;
                    pulses_d = '0;
                end else begin
                    stop_d = stop_req;
                    if (hcnt_q == DIV_LAST) begin
                        hcnt_d = '0;
                        clk_d  = ~clk_q;
                        rise_d = ~clk_q;
                        fall_d = clk_q;
                        if (clk_q != IDLE_LEVEL) begin
                            pulses_d = (pulses_q != '0) ? pulses_q - CNT_ONE : '0;
                            if ((pulses_q <= CNT_ONE) || stop_req) begin
                                state_d  = IDLE;
                                busy_d   = 1'b0;
                                done_d   = 1'b1;
                                stop_d   = 1'b0;
                                pulses_d = '0;
                            end
                        end
                    end else begin
                        hcnt_d = hcnt_q + DIV_ONE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // values, independent of statement order.
        if (rst) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            pulses_q <= '0;
            stop_q   <= 1'b0;
            clk_q    <= IDLE_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            pulses_q <= pulses_d;
            stop_q   <= stop_d;
            clk_q    <= clk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign clk_out   = clk_q;
    assign rise_edge = rise_q;
    assign fall_edge = fall_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bus_clk_generator.sv
// Directed bench for bus_clk_generator: one instance with CLK_DIV=3/idle-low,
// one with CLK_DIV=1/idle-high, expectations computed by hand.
module tb_bus_clk_generator;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       a_rst, a_start, a_stop;
    logic [7:0] a_np;
    logic       a_clk_out, a_rise, a_fall, a_busy, a_done;
    logic       b_rst, b_start, b_stop;
    logic [7:0] b_np;
    logic       b_clk_out, b_rise, b_fall, b_busy, b_done;

    bus_clk_generator #(.CLK_DIV(3), .CNT_WIDTH(8), .IDLE_LEVEL(1'b0)) u_a (
        .sys_clk(sys_clk), .rst(a_rst), .start(a_start), .num_pulses(a_np), .stop(a_stop),
        .clk_out(a_clk_out), .rise_edge(a_rise), .fall_edge(a_fall), .busy(a_busy), .done(a_done)
    );

    bus_clk_generator #(.CLK_DIV(1), .CNT_WIDTH(8), .IDLE_LEVEL(1'b1)) u_b (
        .sys_clk(sys_clk), .rst(b_rst), .start(b_start), .num_pulses(b_np), .stop(b_stop),
        .clk_out(b_clk_out), .rise_edge(b_rise), .fall_edge(b_fall), .busy(b_busy), .done(b_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per-run statistics; indices count edges after the edge that accepted start.
    int   busy_cnt, rise_cnt, fall_cnt, done_cnt, both_cnt, tog_cnt;
    int   done_idx, last_fall, last_rise, first_fall;
    int   rise_at[8];
    bit   busy_at[64];
    logic prev_clk;

    task automatic clear_stats(input logic clk_now);
        busy_cnt = 0; rise_cnt = 0; fall_cnt = 0; done_cnt = 0; both_cnt = 0; tog_cnt = 0;
        done_idx = -1; last_fall = -1; last_rise = -1; first_fall = -1;
        for (int i = 0; i < 8; i++) rise_at[i] = -1;
        for (int i = 0; i < 64; i++) busy_at[i] = 1'b0;
        prev_clk = clk_now;
    endtask

    task automatic sample(input int idx, input logic bz, input logic r, input logic f,
                          input logic d, input logic c);
        if (bz) busy_cnt++;
        if (idx < 64) busy_at[idx] = bz;
        if (r) begin
            if (rise_cnt < 8) rise_at[rise_cnt] = idx;
            rise_cnt++;
            last_rise = idx;
        end
        if (f) begin
            if (fall_cnt == 0) first_fall = idx;
            fall_cnt++;
            last_fall = idx;
        end
        if (d) begin
            done_cnt++;
            done_idx = idx;
        end
        if (r && f) both_cnt++;
        if (c !== prev_clk) tog_cnt++;
        prev_clk = c;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Stimulus hooks applied during run_a (-1 / 0 = unused).
    int start_at, start_np, stop_at, rst_at, b2b_np;

    task automatic clear_hooks();
        start_at = -1; start_np = 0; stop_at = -1; rst_at = -1; b2b_np = 0;
    endtask

    task automatic run_a(input logic [7:0] np, input int ncyc);
        bit b2b_fired;
        b2b_fired = 1'b0;
        clear_stats(a_clk_out);
        a_start = 1'b1;
        a_np    = np;
        tick();
        a_start = 1'b0;
        a_np    = 8'd0;
        for (int i = 0; i < ncyc; i++) begin
            sample(i, a_busy, a_rise, a_fall, a_done, a_clk_out);
            a_start = 1'b0;
            a_stop  = 1'b0;
            a_rst   = 1'b0;
            if (i == start_at) begin
                a_start = 1'b1;
                a_np    = start_np[7:0];
            end
            if (a_done && (b2b_np > 0) && !b2b_fired) begin
                a_start   = 1'b1;
                a_np      = b2b_np[7:0];
                b2b_fired = 1'b1;
            end
            if (i == stop_at) a_stop = 1'b1;
            if (i == rst_at)  a_rst  = 1'b1;
            tick();
        end
        a_start = 1'b0;
        a_stop  = 1'b0;
        a_rst   = 1'b0;
        a_np    = 8'd0;
    endtask

    task automatic check_normal(input string tag);
        check({tag, "_busy"},   busy_cnt, 24);
        check({tag, "_rises"},  rise_cnt, 4);
        check({tag, "_falls"},  fall_cnt, 4);
        check({tag, "_rise0"},  rise_at[0], 3);
        check({tag, "_rise1"},  rise_at[1], 9);
        check({tag, "_rise3"},  rise_at[3], 21);
        check({tag, "_dones"},  done_cnt, 1);
        check({tag, "_doneat"}, done_idx, 24);
        check({tag, "_fall4"},  last_fall, 24);
        check({tag, "_both"},   both_cnt, 0);
        check({tag, "_togs"},   tog_cnt, 8);
    endtask

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_np = 8'd0;
        b_rst = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_np = 8'd0;
        clear_hooks();
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state of both instances.
        check("rst_a_clk",  a_clk_out, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_edge", {a_rise, a_fall}, 0);
        check("rst_b_clk",  b_clk_out, 1);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_edge", {b_rise, b_fall, b_done}, 0);
        tick();

        // Normal 4-pulse burst.
        run_a(8'd4, 30);
        check_normal("norm");

        // Zero-length burst: done next cycle, nothing else moves.
        a_start = 1'b1;
        a_np    = 8'd0;
        tick();
        a_start = 1'b0;
        check("zero_done", a_done, 1);
        check("zero_busy", a_busy, 0);
        check("zero_clk",  a_clk_out, 0);
        check("zero_edge", {a_rise, a_fall}, 0);
        tick();
        check("zero_done2", a_done, 0);
        check("zero_clk2",  a_clk_out, 0);
        tick();

        // Restart mid-burst is ignored; back-to-back start on the done cycle.
        clear_hooks();
        start_at = 8;
        start_np = 9;
        b2b_np   = 2;
        run_a(8'd4, 45);
        check("b2b_rises",  rise_cnt, 6);
        check("b2b_falls",  fall_cnt, 6);
        check("b2b_dones",  done_cnt, 2);
        check("b2b_done2",  done_idx, 37);
        check("b2b_busy",   busy_cnt, 36);
        check("b2b_busy23", busy_at[23], 1);
        check("b2b_busy24", busy_at[24], 0);
        check("b2b_busy25", busy_at[25], 1);
        check("b2b_rise3",  rise_at[3], 21);
        check("b2b_rise4",  rise_at[4], 28);
        tick();

        // Abort while clk_out is high: pulse completes on schedule.
        clear_hooks();
        stop_at = 10;
        run_a(8'd4, 30);
        check("abh_rises",  rise_cnt, 2);
        check("abh_falls",  fall_cnt, 2);
        check("abh_dones",  done_cnt, 1);
        check("abh_doneat", done_idx, 12);
        check("abh_fall",   last_fall, 12);
        check("abh_busy",   busy_cnt, 12);

        // Abort while clk_out is low, on the edge a rise was due.
        clear_hooks();
        stop_at = 14;
        run_a(8'd4, 30);
        check("abl_rises",  rise_cnt, 2);
        check("abl_falls",  fall_cnt, 2);
        check("abl_doneat", done_idx, 15);
        check("abl_busy",   busy_cnt, 15);
        check("abl_togs",   tog_cnt, 4);

        // Reset with clk_out high: silent return to idle, then a normal burst.
        clear_hooks();
        rst_at = 4;
        run_a(8'd4, 10);
        check("rstm_rises", rise_cnt, 1);
        check("rstm_falls", fall_cnt, 0);
        check("rstm_dones", done_cnt, 0);
        check("rstm_busy",  busy_cnt, 5);
        check("rstm_bz5",   busy_at[5], 0);
        check("rstm_togs",  tog_cnt, 2);
        clear_hooks();
        run_a(8'd4, 30);
        check_normal("post");

        // Inverted idle level, divide-by-1.
        clear_stats(b_clk_out);
        b_start = 1'b1;
        b_np    = 8'd3;
        tick();
        b_start = 1'b0;
        b_np    = 8'd0;
        for (int i = 0; i < 10; i++) begin
            sample(i, b_busy, b_rise, b_fall, b_done, b_clk_out);
            tick();
        end
        check("inv_busy",   busy_cnt, 6);
        check("inv_fall0",  first_fall, 1);
        check("inv_rise0",  rise_at[0], 2);
        check("inv_rises",  rise_cnt, 3);
        check("inv_falls",  fall_cnt, 3);
        check("inv_doneat", done_idx, 6);
        check("inv_lrise",  last_rise, 6);
        check("inv_togs",   tog_cnt, 6);
        check("inv_end",    b_clk_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_clk_generator.md
BUS_CLK_GENERATOR -- requirements
Module: bus_clk_generator

Interface
REQ-001 The module SHALL use a single clock, sys_clk; reset is rst, synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- CLK_DIV, default 3: sys_clk cycles per half-period of clk_out (legal range >= 1).
- CNT_WIDTH, default 8: width of num_pulses and the internal pulse counter.
- IDLE_LEVEL, default 0: clk_out level when idle.
REQ-003 Ports SHALL be, one per line:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a burst; sampled on sys_clk rising edge.
- num_pulses  in  CNT_WIDTH  pulse count for the burst; sampled with start.
- stop  in  1  graceful abort request.
- clk_out  out  1  generated bus clock, registered.
- rise_edge  out  1  one-cycle strobe, coincident with clk_out changing 0->1.
- fall_edge  out  1  one-cycle strobe, coincident with clk_out changing 1->0.
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete strobe.

Function
REQ-004 The module SHALL implement the states IDLE and RUN.
REQ-005 In IDLE, start=1 SHALL latch num_pulses, enter RUN, set busy=1 and clear the half-period counter, all on the same edge.
REQ-006 start while busy=1 SHALL be ignored, with no effect on count, timing or latched values.
REQ-007 start with num_pulses=0 SHALL produce done=1 on the next cycle, with busy staying 0 and no clk_out toggle.
REQ-008 In RUN, the half-period counter SHALL count 0..CLK_DIV-1; on reaching CLK_DIV-1, clk_out SHALL toggle and the counter SHALL wrap to 0.
REQ-009 The first toggle SHALL occur CLK_DIV cycles after the edge that accepted start; clk_out first moves away from IDLE_LEVEL.
REQ-010 Each pulse SHALL consist of exactly two toggles (away from IDLE_LEVEL, then back), giving a period of 2*CLK_DIV cycles and a 50% duty cycle.
REQ-011 The pulse counter SHALL decrement on each return-to-idle toggle; no wrap-around is permitted, and it SHALL stop at 0.
REQ-012 On the final return-to-idle toggle:
- done=1 for that cycle only.
- busy=0 from that same edge.
- state returns to IDLE.
- busy total = 2*N*CLK_DIV cycles.
REQ-013 A start on the cycle done=1 SHALL be accepted, giving back-to-back bursts with no idle gap beyond that cycle.
REQ-014 rise_edge and fall_edge SHALL be registered and asserted in exactly the cycles where clk_out shows the new level; they SHALL never assert together or outside RUN.
REQ-015 stop=1 while in RUN SHALL be latched:
- If clk_out=IDLE_LEVEL, the burst SHALL end immediately: done=1 next cycle, no further toggles.
- Otherwise, the current pulse SHALL complete at its scheduled return toggle, with done=1 there.
REQ-016 stop in IDLE SHALL be ignored; stop and start in the same IDLE cycle SHALL give start priority.
REQ-017 clk_out SHALL be glitch-free: at most one change per CLK_DIV cycles, driven directly from a flop.

Reset
REQ-018 rst=1 SHALL, on the next sys_clk edge, force the following, regardless of state, including mid-pulse:
- state=IDLE.
- clk_out=IDLE_LEVEL.
- rise_edge=0, fall_edge=0, busy=0, done=0.
- all counters and the stop latch cleared.
REQ-019 A reset mid-burst SHALL NOT produce done or an edge strobe; clk_out returns to idle without an accompanying strobe.
REQ-020 rst SHALL take priority over start and stop in the same cycle.

Verification
REQ-021 Normal burst: CLK_DIV=3, IDLE_LEVEL=0, num_pulses=4 -> busy high 24 cycles, 4 rise_edge and 4 fall_edge strobes, rises 6 cycles apart, first rise 3 cycles after start, done once coincident with the 4th fall.
REQ-022 Zero count: num_pulses=0 -> done=1 on the next cycle, busy=0, clk_out constant 0.
REQ-023 Ignored restart: start re-pulsed with num_pulses=9 during a 4-pulse burst -> still exactly 4 pulses and the original 24-cycle busy window; back-to-back start on the done cycle -> second burst begins with no gap.
REQ-024 Abort: stop asserted 1 cycle after the 2nd rise (clk_out=1) -> 2nd fall occurs at its scheduled time with done, totalling 2 pulses; stop asserted while clk_out=0 -> done next cycle, 2 pulses total.
REQ-025 Reset mid-pulse: rst asserted while clk_out=1 -> clk_out=0, busy=0 on the next edge, no done, no fall_edge; a new start afterwards behaves as REQ-021.
REQ-026 Inverted idle: IDLE_LEVEL=1, CLK_DIV=1, num_pulses=3 -> first strobe fall_edge, clk_out toggles every cycle, busy high 6 cycles, ends high with rise_edge+done.
